trit_pack_ctrl: RTL

- Sequencer for the iterative 5-trit to 8-bit packer (trit5_to_bit8) in the NTRU-HRSS encaps packing path.
- Accepts a stream of N_COEF trits per polynomial, groups them 5 at a time and loads each group into the converter.
- Drives the converter's load/count sequence, captures each resulting byte and emits it on a valid/ready byte stream.
- Zero-pads the final partial group.

---
 rtl/trit_pack_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/trit_pack_ctrl.sv
// trit_pack_ctrl
// Sequencer for the iterative 5-trit to 8-bit converter (trit5_to_bit8).
// It collects N_COEF trits per polynomial, five per group, and zero-pads the
// final partial group. Each group is loaded into the converter, which is then
// stepped through counts 3,2,1,0. The resulting byte is emitted on a
// valid/ready stream.
//
// Optional build macro: TRIT_CHECK_EN
//   When defined, an accepted illegal trit (2'b11) is stored as 2'b00, and
//   the sticky output 'err' is added to the port list.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           one-cycle pulse that begins a polynomial (IDLE only)
//   t_valid/t_ready trit stream handshake; t_data = {b1,b0}
//   conv_load       converter load/reset strobe
//   conv_count      converter step index (3,2,1,0 during conversion)
//   conv_trits      group register, trit k at bits [2k+1:2k]
//   conv_byte       converter result
//   b_valid/b_ready packed byte stream handshake; b_data = byte
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse after the last byte of a polynomial
//   err             sticky illegal-trit flag (TRIT_CHECK_EN only)

module trit_pack_ctrl #(
    parameter int N_COEF = 701,
    parameter int CNT_W  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        t_valid,
    input  logic [1:0]  t_data,
    output logic        t_ready,
    output logic        conv_load,
    output logic [1:0]  conv_count,
    output logic [9:0]  conv_trits,
    input  logic [7:0]  conv_byte,
    output logic        b_valid,
    output logic [7:0]  b_data,
    input  logic        b_ready,
    output logic        busy,
`ifdef TRIT_CHECK_EN
    output logic        done,
    output logic        err
`else
    output logic        done
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_COEF - 1);
    localparam logic [CNT_W-1:0] COEF_TOTAL = CNT_W'(N_COEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_CONV,
        S_CAPT,
        S_OUT,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_coef_cnt;
    logic [2:0]         r_grp_idx;
    logic [9:0]         r_trits;
    logic [1:0]         r_dcnt;
    logic               r_b_valid;
    logic [7:0]         r_b_data;
    logic               w_accept;
    logic [1:0]         w_trit;

    assign w_accept = (r_state == S_FILL) && t_valid;

`ifdef TRIT_CHECK_EN
    logic r_err;
    assign w_trit = (t_data == 2'b11) ? 2'b00 : t_data;
    assign err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && (t_data == 2'b11)) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_trit = t_data;
`endif

    assign conv_trits = r_trits;
    assign b_valid    = r_b_valid;
    assign b_data     = r_b_data;

    // Next state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        t_ready    = 1'b0;
        conv_load  = 1'b0;
        conv_count = 2'b00;
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FILL;
            end
            S_FILL: begin
                t_ready = 1'b1;
                // Leave on the trit that completes a group or the polynomial
                if (w_accept && ((r_grp_idx == 3'd4) || (r_coef_cnt == LAST_IDX)))
                    w_next = S_LOAD;
            end
            S_LOAD: begin
                conv_load = 1'b1;
                w_next    = S_CONV;
            end
            S_CONV: begin
                conv_count = r_dcnt;
                if (r_dcnt == 2'd0) w_next = S_CAPT;
            end
            S_CAPT: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (b_ready)
                    w_next = (r_coef_cnt == COEF_TOTAL) ? S_FIN : S_FILL;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_coef_cnt <= '0;
            r_grp_idx  <= '0;
            r_trits    <= '0;
            r_dcnt     <= '0;
            r_b_valid  <= 1'b0;
            r_b_data   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_coef_cnt <= '0;
                        r_grp_idx  <= '0;
                        r_trits    <= '0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        for (int unsigned k = 0; k < 5; k++) begin
                            if (r_grp_idx == 3'(k)) r_trits[2*k +: 2] <= w_trit;
                        end
                        r_grp_idx  <= r_grp_idx + 3'd1;
                        r_coef_cnt <= r_coef_cnt + 1'b1;
                    end
                end
                S_LOAD: r_dcnt <= 2'd3;
                S_CONV: r_dcnt <= r_dcnt - 2'd1;
                S_CAPT: begin
                    r_b_data  <= conv_byte;
                    r_b_valid <= 1'b1;
                end
                S_OUT: begin
                    if (b_ready) begin
                        r_b_valid <= 1'b0;
                        r_trits   <= '0;
                        r_grp_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
